pc_stack_unit: RTL and testbench

- Parametrised next-generation program-counter unit for the Gumnut core family.
- Generates the instruction address and performs sequential, branch, jump, subroutine and interrupt flow control.
- Adds a configurable-depth return stack that saves condition flags on interrupt entry, supports nested interrupts, and reports overflow/underflow.
- Driven by the control unit's PC operation code and the processing unit's condition codes.

---
 rtl/pc_stack_unit.sv | 148 ++++++++++++++
 tb/tb_pc_stack_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// Program-counter unit with a LIFO return stack for calls and interrupts.
// Interrupt entries carry the Z/C flags, which RETI hands back to the core.
module pc_stack_unit #(
  parameter int ADDR_W  = 12,
  parameter int DISP_W  = 8,
  parameter int DEPTH   = 8,
  parameter int RST_VEC = 0,
  parameter int INT_VEC = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clk_en_i,
  input  logic                       pc_en_i,
  input  logic [3:0]                 pc_op_i,
  input  logic                       cc_c_i,
  input  logic                       cc_z_i,
  input  logic [DISP_W-1:0]          disp_i,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic                       clr_err_i,
  output logic [ADDR_W-1:0]          inst_addr_o,
  output logic                       flag_rst_o,
  output logic                       intc_o,
  output logic                       intz_o,
  output logic                       int_active_o,
  output logic [$clog2(DEPTH+1)-1:0] depth_o,
  output logic                       ovf_o,
  output logic                       unf_o
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [3:0] {
    OP_INC, OP_BZ, OP_BNZ, OP_BC, OP_BNC, OP_JMP, OP_JSB, OP_RET, OP_INT, OP_RETI
  } op_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              z;
    logic              c;
  } entry_t;

  entry_t            stack_mem [DEPTH];
  entry_t            push_data, top;
  logic              push_en;
  logic [CNT_W-1:0]  sp, level;
  logic [IDX_W-1:0]  top_idx;
  logic [ADDR_W-1:0] pc, inc, btgt, disp_ext;
  logic              act, full, empty;
  op_e               op;

  assign act      = clk_en_i & pc_en_i;
  assign op       = op_e'(pc_op_i);
  assign disp_ext = ADDR_W'($signed(disp_i));
  assign inc      = pc + ADDR_W'(1);
  assign btgt     = inc + disp_ext;
  assign full     = (sp == CNT_W'(DEPTH));
  assign empty    = (sp == '0);
  assign top_idx  = empty ? '0 : IDX_W'(sp - CNT_W'(1));
  assign top      = stack_mem[top_idx];

  assign inst_addr_o  = pc;
  assign depth_o      = sp;
  assign int_active_o = (level != '0);

  // A push on a full stack is dropped; only the error flag records it.
  always_comb begin
    push_en   = 1'b0;
    push_data = '0;
    if (act && !full) begin
      if (op == OP_JSB) begin
        push_en   = 1'b1;
        push_data = '{addr: inc, z: 1'b0, c: 1'b0};
      end else if (op == OP_INT) begin
        push_en   = 1'b1;
        push_data = '{addr: pc, z: cc_z_i, c: cc_c_i};
      end
    end
  end

  // Contents need no reset: the pointer alone defines what is valid.
  always_ff @(posedge clk_i) begin
    if (push_en) stack_mem[IDX_W'(sp)] <= push_data;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc         <= ADDR_W'(RST_VEC);
      sp         <= '0;
      level      <= '0;
      flag_rst_o <= 1'b0;
      intz_o     <= 1'b0;
      intc_o     <= 1'b0;
      ovf_o      <= 1'b0;
      unf_o      <= 1'b0;
    end else begin
      flag_rst_o <= 1'b0;
      // Clear first so a coincident new error wins below.
      if (clr_err_i) begin
        ovf_o <= 1'b0;
        unf_o <= 1'b0;
      end
      if (act) begin
        case (op)
          OP_INC: pc <= inc;
          OP_BZ:  pc <= cc_z_i  ? btgt : inc;
          OP_BNZ: pc <= !cc_z_i ? btgt : inc;
          OP_BC:  pc <= cc_c_i  ? btgt : inc;
          OP_BNC: pc <= !cc_c_i ? btgt : inc;
          OP_JMP: pc <= addr_i;
          OP_JSB: begin
            pc <= addr_i;
            if (full) ovf_o <= 1'b1;
            else      sp    <= sp + CNT_W'(1);
          end
          OP_RET: begin
            if (empty) begin
              unf_o <= 1'b1;
              pc    <= inc;
            end else begin
              pc <= top.addr;
              sp <= sp - CNT_W'(1);
            end
          end
          OP_INT: begin
            pc <= ADDR_W'(INT_VEC);
            if (full) ovf_o <= 1'b1;
            else      sp    <= sp + CNT_W'(1);
            if (level != CNT_W'(DEPTH)) level <= level + CNT_W'(1);
          end
          OP_RETI: begin
            if (level != '0) level <= level - CNT_W'(1);
            if (empty) begin
              unf_o <= 1'b1;
              pc    <= inc;
            end else begin
              pc         <= top.addr;
              sp         <= sp - CNT_W'(1);
              intz_o     <= top.z;
              intc_o     <= top.c;
              flag_rst_o <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pc_stack_unit.sv
// Randomized scoreboard bench for pc_stack_unit against a queue-based flow model.
module tb_pc_stack_unit;
  localparam int ADDR_W = 12, DISP_W = 8, DEPTH = 8, RST_VEC = 0, INT_VEC = 1;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int MASK  = (1 << ADDR_W) - 1;

  logic              clk = 0, rst_n = 0;
  logic              clk_en = 0, pc_en = 0, cc_c = 0, cc_z = 0, clr_err = 0;
  logic [3:0]        pc_op = 0;
  logic [DISP_W-1:0] disp_in = 0;
  logic [ADDR_W-1:0] addr_in = 0;
  logic [ADDR_W-1:0] inst_addr_o;
  logic              flag_rst_o, intc_o, intz_o, int_active_o, ovf_o, unf_o;
  logic [CNT_W-1:0]  depth_o;

  pc_stack_unit #(.ADDR_W(ADDR_W), .DISP_W(DISP_W), .DEPTH(DEPTH),
                  .RST_VEC(RST_VEC), .INT_VEC(INT_VEC)) dut (
    .clk_i(clk), .rst_i(rst_n), .clk_en_i(clk_en), .pc_en_i(pc_en),
    .pc_op_i(pc_op), .cc_c_i(cc_c), .cc_z_i(cc_z), .disp_i(disp_in),
    .addr_i(addr_in), .clr_err_i(clr_err), .inst_addr_o(inst_addr_o),
    .flag_rst_o(flag_rst_o), .intc_o(intc_o), .intz_o(intz_o),
    .int_active_o(int_active_o), .depth_o(depth_o), .ovf_o(ovf_o), .unf_o(unf_o)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; bit z; bit c; } ent_t;
  typedef struct { string name; int pc; int depth; bit ovf, unf, frst, z, c, active; } exp_t;

  ent_t m_stk[$];
  int   m_pc, m_level;
  bit   m_ovf, m_unf, m_frst, m_z, m_c;
  exp_t exp_q[$];
  int   vectors = 0, miscompares = 0;

  function automatic void model_reset();
    m_stk.delete();
    m_pc = RST_VEC; m_level = 0;
    m_ovf = 0; m_unf = 0; m_frst = 0; m_z = 0; m_c = 0;
  endfunction

  function automatic void model_step(int op, bit z, bit c, int disp, int addr,
                                     bit clr, bit act);
    int   d, inc, btgt;
    ent_t e;
    d    = disp & 255;
    if (d >= 128) d -= 256;
    inc  = (m_pc + 1) & MASK;
    btgt = (m_pc + 1 + d) & MASK;
    m_frst = 0;
    if (clr) begin m_ovf = 0; m_unf = 0; end
    if (!act) return;
    case (op)
      0: m_pc = inc;
      1: m_pc = z  ? btgt : inc;
      2: m_pc = !z ? btgt : inc;
      3: m_pc = c  ? btgt : inc;
      4: m_pc = !c ? btgt : inc;
      5: m_pc = addr & MASK;
      6: begin
        if (m_stk.size() == DEPTH) m_ovf = 1;
        else m_stk.push_back('{inc, 1'b0, 1'b0});
        m_pc = addr & MASK;
      end
      7: begin
        if (m_stk.size() == 0) begin m_unf = 1; m_pc = inc; end
        else begin e = m_stk.pop_back(); m_pc = e.addr; end
      end
      8: begin
        if (m_stk.size() == DEPTH) m_ovf = 1;
        else m_stk.push_back('{m_pc, z, c});
        m_pc = INT_VEC;
        if (m_level < DEPTH) m_level++;
      end
      9: begin
        if (m_level > 0) m_level--;
        if (m_stk.size() == 0) begin m_unf = 1; m_pc = inc; end
        else begin
          e = m_stk.pop_back();
          m_pc = e.addr; m_z = e.z; m_c = e.c; m_frst = 1;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic exp_t snapshot(string nm);
    exp_t e;
    e.name = nm; e.pc = m_pc; e.depth = m_stk.size();
    e.ovf = m_ovf; e.unf = m_unf; e.frst = m_frst; e.z = m_z; e.c = m_c;
    e.active = (m_level != 0);
    return e;
  endfunction

  task automatic check(input exp_t e);
    vectors++;
    if (inst_addr_o !== ADDR_W'(e.pc) || depth_o !== CNT_W'(e.depth) ||
        ovf_o !== e.ovf || unf_o !== e.unf || flag_rst_o !== e.frst ||
        intz_o !== e.z || intc_o !== e.c || int_active_o !== e.active) begin
      miscompares++;
      $display("FAIL %s @%0t: got pc=%03h dep=%0d ovf=%b unf=%b frst=%b z=%b c=%b act=%b, expected pc=%03h dep=%0d ovf=%b unf=%b frst=%b z=%b c=%b act=%b",
               e.name, $time, inst_addr_o, depth_o, ovf_o, unf_o, flag_rst_o, intz_o, intc_o,
               int_active_o, e.pc, e.depth, e.ovf, e.unf, e.frst, e.z, e.c, e.active);
    end
  endtask

  task automatic apply(input string nm, input int op, input bit z = 0, input bit c = 0,
                       input int disp = 0, input int addr = 0, input bit clr = 0,
                       input bit ce = 1, input bit pe = 1);
    @(negedge clk);
    clk_en = ce; pc_en = pe; pc_op = 4'(op); cc_z = z; cc_c = c;
    disp_in = DISP_W'(disp); addr_in = ADDR_W'(addr); clr_err = clr;
    model_step(op, z, c, disp, addr, clr, ce & pe);
    exp_q.push_back(snapshot(nm));
  endtask

  // Reset lands between edges and is checked before any clock edge.
  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 0;
    model_reset();
    #1 check(snapshot("async_rst"));
    @(posedge clk); #3;
    rst_n = 1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check(e);
      end
    end
  end

  initial begin : stimulus
    int op;
    bit ce, pe;
    model_reset();
    do_reset();
    repeat (3) apply("inc", 0);
    apply("hold_ce0", 0, .ce(0));
    apply("hold_ce0", 0, .ce(0));
    apply("jmp", 5, .addr('h010));
    apply("bz_taken_neg", 1, .z(1), .disp('hFE));
    apply("bnz_not_taken", 2, .z(1), .disp('h40));
    apply("jmp", 5, .addr('hFFF));
    apply("bc_wrap", 3, .c(1), .disp('h01));
    apply("jmp", 5, .addr('h020));
    apply("jsb", 6, .addr('h100));
    apply("ret", 7);
    apply("jmp", 5, .addr('h030));
    apply("int_outer", 8, .z(1), .c(0));
    apply("inc", 0);
    apply("int_nested", 8, .z(0), .c(1));
    apply("reti_inner", 9);
    apply("frst_drop", 0, .pe(0));
    apply("reti_outer", 9);
    apply("after_reti", 0);
    for (int i = 0; i < 9; i++) apply("jsb_fill", 6, .addr(i * 16));
    for (int i = 0; i < 9; i++) apply("ret_drain", 7);
    apply("clr_err", 0, .clr(1));
    apply("jsb_clr_coincide", 6, .addr('h200));
    for (int i = 0; i < 8; i++) apply("jsb_fill2", 6, .addr('h300));
    apply("ovf_beats_clr", 6, .addr('h111), .clr(1));
    apply("clr_err", 0, .clr(1));
    do_reset();
    for (int i = 0; i < 3; i++) apply("jsb", 6, .addr('h050 + i));
    do_reset();
    apply("first_after_rst", 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      ce = ($urandom_range(0, 9) != 0);
      pe = ($urandom_range(0, 4) != 0);
      op = $urandom_range(0, 15);
      apply("random", op, 1'($urandom), 1'($urandom), int'($urandom_range(0, 255)),
            int'($urandom_range(0, MASK)), (ce & pe) && ($urandom_range(0, 19) == 0), ce, pe);
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
